// File: rtl/me_min_sad.sv
// Motion-estimation minimum-SAD tracker over a serpentine,
// column-major candidate scan; reports best SAD and its vector.
module me_min_sad #(
  parameter int POS_DIM = 32,
  parameter int SAD_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              valid,
  input  logic [SAD_W-1:0]  sad,
  output logic              busy,
  output logic              done,
  output logic [SAD_W-1:0]  min_sad,
  output logic signed [5:0] mv_x,
  output logic signed [5:0] mv_y
);

  localparam int CW = $clog2(POS_DIM);
  localparam logic [CW-1:0] RMAX = CW'(POS_DIM - 1);
  localparam logic [5:0]    HALF = 6'(POS_DIM / 2);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [SAD_W-1:0]  min_q, min_d;
  logic signed [5:0] mvx_q, mvx_d;
  logic signed [5:0] mvy_q, mvy_d;

  logic [CW-1:0] y;
  logic          row_end;
  logic          last;

  // Odd columns are walked bottom-up.
  assign y       = col_q[0] ? (RMAX - row_q) : row_q;
  assign row_end = (row_q == RMAX);
  assign last    = row_end && (col_q == RMAX);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    min_d   = min_q;
    mvx_d   = mvx_q;
    mvy_d   = mvy_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          row_d   = '0;
          col_d   = '0;
          min_d   = '1;
          mvx_d   = '0;
          mvy_d   = '0;
        end
      end
      SCAN: begin
        if (valid) begin
          row_d = row_end ? '0 : row_q + CW'(1);
          if (row_end) begin
            col_d = col_q + CW'(1);
          end
          if (sad < min_q) begin
            min_d = sad;
            mvx_d = 6'(col_q) - HALF;
            mvy_d = 6'(y) - HALF;
          end
          if (last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      min_q   <= '1;
      mvx_q   <= '0;
      mvy_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      min_q   <= min_d;
      mvx_q   <= mvx_d;
      mvy_q   <= mvy_d;
    end
  end

  assign busy    = (state_q == SCAN);
  assign done    = (state_q == DONE);
  assign min_sad = min_q;
  assign mv_x    = mvx_q;
  assign mv_y    = mvy_q;

endmodule

// File: tb/tb_me_min_sad.sv
// Directed bench for me_min_sad: full 32x32 scans with
// hand-placed minima, ties, ignored strobes and mid-scan reset.
module tb_me_min_sad;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              valid;
  logic [15:0]       sad;
  logic              busy;
  logic              done;
  logic [15:0]       min_sad;
  logic signed [5:0] mv_x;
  logic signed [5:0] mv_y;

  int total;
  int bad;

  logic [15:0] sadv [1024];

  me_min_sad #(
    .POS_DIM(32),
    .SAD_W  (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .valid  (valid),
    .sad    (sad),
    .busy   (busy),
    .done   (done),
    .min_sad(min_sad),
    .mv_x   (mv_x),
    .mv_y   (mv_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 1024; i++) sadv[i] = v;
  endtask

  // Start a search, feed all 1024 candidates, leave DUT in DONE.
  task automatic scan(input bit gaps,
                      input bit vs_start,
                      input bit mid_start,
                      output int early,
                      output int nobusy);
    early  = 0;
    nobusy = 0;
    start  = 1'b1;
    valid  = vs_start;
    sad    = 16'd0;
    tick();
    start = 1'b0;
    valid = 1'b0;
    for (int k = 0; k < 1024; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          if (!busy) nobusy++;
          if (done) early++;
        end
      end
      valid = 1'b1;
      sad   = sadv[k];
      if (mid_start && (k % 200 == 5)) start = 1'b1;
      tick();
      valid = 1'b0;
      start = 1'b0;
      if (k < 1023) begin
        if (done) early++;
        if (!busy) nobusy++;
      end
    end
  endtask

  task automatic finish_chk(input string tag,
                            input int early,
                            input int nobusy,
                            input logic [15:0] emin,
                            input int ex,
                            input int ey);
    chk({tag, "_early"}, 32'(early), 32'd0);
    chk({tag, "_busy"}, 32'(nobusy), 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_min"}, {16'd0, min_sad}, {16'd0, emin});
    chk({tag, "_mvx"}, 32'(mv_x), 32'(ex));
    chk({tag, "_mvy"}, 32'(mv_y), 32'(ey));
    tick();
    chk({tag, "_done1"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hold"}, {16'd0, min_sad}, {16'd0, emin});
  endtask

  initial begin
    int early;
    int nobusy;
    int dcnt;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    valid = 1'b0;
    sad   = 16'd0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_min", {16'd0, min_sad}, 32'h0000ffff);
    chk("rst_mvx", 32'(mv_x), 32'd0);
    chk("rst_mvy", 32'(mv_y), 32'd0);
    rst_n = 1'b1;
    tick();

    fill(16'd1000);
    sadv[0] = 16'd10;
    scan(1'b0, 1'b0, 1'b0, early, nobusy);
    finish_chk("t1", early, nobusy, 16'd10, -16, -16);

    fill(16'd1000);
    sadv[32] = 16'd5;
    scan(1'b0, 1'b0, 1'b0, early, nobusy);
    finish_chk("t2", early, nobusy, 16'd5, -15, 15);

    fill(16'd500);
    scan(1'b0, 1'b0, 1'b0, early, nobusy);
    finish_chk("t3", early, nobusy, 16'd500, -16, -16);

    for (int i = 0; i < 1024; i++) sadv[i] = 16'($urandom_range(1, 65535));
    sadv[528] = 16'd0;
    scan(1'b1, 1'b0, 1'b0, early, nobusy);
    finish_chk("t4", early, nobusy, 16'd0, 0, 0);

    // Earliest of two equal minima: k=100 is col 3, row 4 -> y=27.
    fill(16'd900);
    sadv[100] = 16'd7;
    sadv[900] = 16'd7;
    scan(1'b0, 1'b0, 1'b0, early, nobusy);
    finish_chk("tie", early, nobusy, 16'd7, -13, 11);

    // Largest-corner candidate: k=1023 is col 31, odd -> y=0.
    fill(16'hffff);
    sadv[1023] = 16'd3;
    scan(1'b0, 1'b0, 1'b0, early, nobusy);
    finish_chk("last", early, nobusy, 16'd3, 15, -16);

    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1;
      sad   = 16'd0;
      tick();
      valid = 1'b0;
      if (done || busy) dcnt++;
    end
    chk("idle_valid", 32'(dcnt), 32'd0);
    chk("idle_min", {16'd0, min_sad}, 32'd3);

    fill(16'd800);
    sadv[64] = 16'd20;
    scan(1'b0, 1'b1, 1'b1, early, nobusy);
    finish_chk("t5", early, nobusy, 16'd20, -14, -16);

    fill(16'd700);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 500; k++) begin
      valid = 1'b1;
      sad   = (k == 10) ? 16'd1 : sadv[k];
      tick();
      valid = 1'b0;
    end
    chk("pre_rst_min", {16'd0, min_sad}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_min", {16'd0, min_sad}, 32'h0000ffff);
    chk("arst_mvx", 32'(mv_x), 32'd0);
    chk("arst_mvy", 32'(mv_y), 32'd0);
    tick();
    rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 1030; k++) begin
      valid = 1'b1;
      sad   = 16'd2;
      tick();
      valid = 1'b0;
      if (done || busy) dcnt++;
    end
    chk("post_rst_done", 32'(dcnt), 32'd0);
    chk("post_rst_min", {16'd0, min_sad}, 32'h0000ffff);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
